// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the forwarding / hazard unit.
package hazard_pkg;

    // fwd_sel code meaning "take the operand from the register file"
    localparam int FWD_SEL_RF = 0;

    // Producer latencies, in cycles until the result is on the EX/MEM path
    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 7;

    // Width of one forwarding select: encodes register file plus NUM_FWD stages
    function automatic int sel_w(input int num_fwd);
        return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_prio_select.sv
// Priority encoder for one source operand: picks the youngest forwarding
// stage whose destination matches, or the register file when none does.
module fwd_prio_select
    import hazard_pkg::*;
#(
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]         src,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]            fwd_we,
    output logic [SEL_W-1:0]              sel
);

    // Scan oldest-to-youngest so the lowest matching stage is the last writer
    always_comb begin
        // NOTE: the default assignment up front covers every path, so no latch is inferred.
        sel = SEL_W'(FWD_SEL_RF);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_we[k] &&
                fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == src &&
                fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] != '0) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and latency-scoreboard stall generation beside ID/EX.
// Optional stall-cycle performance counter enabled by FWD_HAZARD_PERF_EN;
// when undefined perf_stall_cnt reads 0 and no counter flops exist.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               id_valid,
    input  logic [REG_ADDR_W-1:0]              id_rd,
    input  logic                               id_we,
    input  logic [LAT_W-1:0]                   id_lat,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]      id_src,
    input  logic [NUM_SRC-1:0]                 id_src_used,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]      ex_src,
    input  logic [NUM_FWD*REG_ADDR_W-1:0]      fwd_rd,
    input  logic [NUM_FWD-1:0]                 fwd_we,
    input  logic                               flush,
    output logic [NUM_SRC*sel_w(NUM_FWD)-1:0]  fwd_sel,
    output logic                               stall,
    output logic [31:0]                        perf_stall_cnt
);

    localparam int SEL_W    = sel_w(NUM_FWD);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [LAT_W-1:0] busy_q [NUM_REGS];
    logic [LAT_W-1:0] busy_d [NUM_REGS];
    logic [LAT_W-1:0] lat_eff;
    logic             raw_hit;
    logic             waw_hit;
    logic             issue;

    // One priority encoder per EX operand
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sel
        fwd_prio_select #(
            .NUM_FWD   (NUM_FWD),
            .REG_ADDR_W(REG_ADDR_W),
            .SEL_W     (SEL_W)
        ) u_sel (
            .src   (ex_src[i*REG_ADDR_W +: REG_ADDR_W]),
            .fwd_rd(fwd_rd),
            .fwd_we(fwd_we),
            .sel   (fwd_sel[i*SEL_W +: SEL_W])
        );
    end

    // Hazard detection from the live counters; a zero latency counts as one
    always_comb begin
        lat_eff = (id_lat == '0) ? LAT_W'(1) : id_lat;
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && id_src[i*REG_ADDR_W +: REG_ADDR_W] != '0 &&
                busy_q[id_src[i*REG_ADDR_W +: REG_ADDR_W]] > LAT_W'(1)) begin
                raw_hit = 1'b1;
            end
        end
        waw_hit = id_we && id_rd != '0 && busy_q[id_rd] > lat_eff;
        stall   = rst_n && id_valid && (raw_hit || waw_hit) && !flush;
        issue   = id_valid && !stall && !flush;
    end

    // Next counter values: flush clears, issue sets, everything else counts down
    always_comb begin
        busy_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_d[r] = (busy_q[r] != '0) ? busy_q[r] - LAT_W'(1) : '0;
            if (flush) begin
                busy_d[r] = '0;
            end else if (issue && id_we && id_rd == REG_ADDR_W'(r)) begin
                busy_d[r] = lat_eff;
            end
        end
    end

    // Scoreboard counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the scoreboard array is reset because stale counts would raise false stalls.
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= busy_d[r];
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_q;
    logic [31:0] perf_d;

    // Stall-cycle counter, wraps naturally and survives flush
    always_comb begin
        perf_d = perf_q + 32'(stall);
    end

    // Performance counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined core.
- Per operand, selects the youngest valid forwarding stage; the register file is used when no stage matches.
- A per-register latency scoreboard tracks in-flight writes from variable-latency producers (ALU, load, multi-cycle MUL/DIV). It raises a stall for RAW and WAW hazards that forwarding cannot cover.
- Sits beside the ID/EX boundary and drives the EX operand muxes and the ID stall/bubble logic.

Parameters:
- NUM_SRC, 2: source operands per instruction.
- NUM_FWD, 2: forwarding stages. Index 0 = EX/MEM (youngest), index 1 = MEM/WB, and so on.
- REG_ADDR_W, 5: register address width. NUM_REGS = 2**REG_ADDR_W.
- LAT_W, 3: scoreboard counter width. Maximum producer latency is 2**LAT_W-1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  the ID-stage instruction is valid.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_we  in  1  ID instruction writes rd.
- id_lat  in  LAT_W  cycles until the result reaches the EX/MEM forwarding path. 1 = ALU, 2 = load.
- id_src  in  NUM_SRC*REG_ADDR_W  ID source registers.
- id_src_used  in  NUM_SRC  the source is actually read.
- ex_src  in  NUM_SRC*REG_ADDR_W  ID/EX source registers.
- fwd_rd  in  NUM_FWD*REG_ADDR_W  destination register per forwarding stage.
- fwd_we  in  NUM_FWD  RegWrite per forwarding stage.
- flush  in  1  pipeline flush.
- fwd_sel  out  NUM_SRC*SEL_W  per operand. 0 = register file; k = stage k-1. SEL_W = clog2(NUM_FWD+1).
- stall  out  1  hold PC/IF/ID and insert a bubble into ID/EX.
- perf_stall_cnt  out  32  stall-cycle count. See Optional Feature.

Behaviour:
- fwd_sel[i] (combinational): the lowest stage k with fwd_we[k] && fwd_rd[k]==ex_src[i] && fwd_rd[k]!=0 gives k+1. If no stage matches, 0. The youngest stage always wins.
- Scoreboard: busy[r] is an LAT_W down-counter for each r in 1..NUM_REGS-1. busy[0] is hardwired 0.
- issue = id_valid && !stall && !flush.
- Counter update on each clock edge:
  - If issue && id_we && id_rd!=0: busy[id_rd] <= max(id_lat,1). Set has priority over decrement.
  - All other nonzero counters decrement by 1. Counters saturate at 0.
- RAW stall: for any i, id_valid && id_src_used[i] && id_src[i]!=0 && busy[id_src[i]]>1.
- WAW stall: id_valid && id_we && id_rd!=0 && busy[id_rd]>max(id_lat,1). This prevents out-of-order completion onto the same register.
- stall = (RAW || WAW) && !flush. It is combinational from the counters and ID inputs.
- Latency 1 (ALU) never stalls. Load-use (lat 2) stalls exactly 1 cycle. Lat L stalls L-1 cycles for a back-to-back consumer.
- flush: all counters go to 0 on the next edge, and no issue occurs that cycle. stall is 0 while flush is high.
- Reset (async, rst_n low): all counters 0, perf counter 0. stall is forced 0 while rst_n is low. fwd_sel follows its inputs and is 0 when all fwd_we are 0.
- Reset deasserted mid-operation: all prior scoreboard state is lost. Upstream flushes the pipeline.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined: perf_stall_cnt increments on every cycle with stall==1. It wraps at 2**32 and clears on reset. flush does not clear it.
- When undefined: perf_stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - FWD_SEL_RF = 0.
  - A clog2-based SEL_W function.
  - Latency constants LAT_ALU = 1, LAT_LOAD = 2, LAT_MUL = 3, LAT_DIV = 7.
- Sub-module fwd_prio_select: one priority encoder per source operand, instantiated NUM_SRC times via generate. The scoreboard stays in the top level.

Test Plan:
- ALU x5 issued (lat 1), consumer of x5 next cycle in ID → stall = 0. When it reaches EX with fwd_rd[0]=5 and fwd_we[0]=1 → fwd_sel = 1.
- Load x6 (lat 2), dependent next → stall = 1 for exactly 1 cycle, then fwd_sel = 2 (MEM/WB) in EX.
- Stage 0 and stage 1 both write x7, ex_src = 7 → fwd_sel = 1. With rd = 0 and fwd_we = 1 → fwd_sel = 0.
- DIV x8 (lat 7), then ALU write x8 (lat 1) → WAW stall 6 cycles. The ALU write issues in the cycle busy[x8] reads 1.
- MUL x9 (lat 3) in flight, flush pulse → busy cleared next edge. A dependent of x9 then sees stall = 0. rst_n low mid-stall → stall drops immediately.
- With FWD_HAZARD_PERF_EN: 3 load-use pairs → perf_stall_cnt = 3. Without the macro → it reads 0.
